// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NREQ byte-stream
// requesters. Round-robin arbitration at message granularity, with optional
// "<id>:" header and CR LF trailer framing and a mid-message idle timeout.
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADD_FRAME = 1,
  parameter int TIMEOUT   = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] data,
  input  logic [NREQ-1:0]   last,
  output logic [NREQ-1:0]   ack,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              abort,
  output logic              wr_uart,
  output logic [7:0]        w_data,
  input  logic              tx_full
);

  localparam int IDXW = $clog2(NREQ);
  localparam int CW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE,
    HDR_ID,
    HDR_SEP,
    PAYLOAD,
    TRL_CR,
    TRL_LF
  } state_t;

  state_t            state, state_n;
  logic [NREQ-1:0]   grant_n;
  logic [IDXW-1:0]   owner, owner_n;
  logic [IDXW-1:0]   rr_ptr, rr_n;
  logic [IDXW-1:0]   cand;
  logic [IDXW-1:0]   win_idx;
  logic              win_found;
  logic [CW-1:0]     cnt, cnt_n;
  logic              req_own;
  logic              last_own;
  logic [7:0]        data_own;

  // Round-robin pick: first requester strictly after rr_ptr, wrapping around.
  always_comb begin
    cand      = rr_ptr;
    win_idx   = rr_ptr;
    win_found = 1'b0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDXW'((32'(rr_ptr) + k) % NREQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Owner's request, last flag and byte, selected through the one-hot grant.
  always_comb begin
    req_own  = |(req & grant);
    last_own = |(last & grant);
    data_own = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        data_own = data_own | data[8*i +: 8];
      end
    end
  end

  // Next-state, grant/pointer/timeout updates and UART-facing outputs.
  always_comb begin
    state_n = state;
    grant_n = grant;
    owner_n = owner;
    rr_n    = rr_ptr;
    cnt_n   = cnt;
    wr_uart = 1'b0;
    w_data  = 8'h00;
    ack     = '0;
    abort   = 1'b0;
    busy    = (state != IDLE);
    case (state)
      IDLE: begin
        if (win_found) begin
          grant_n = NREQ'(1) << win_idx;
          owner_n = win_idx;
          rr_n    = win_idx;
          cnt_n   = '0;
          state_n = (ADD_FRAME != 0) ? HDR_ID : PAYLOAD;
        end
      end
      HDR_ID: begin
        wr_uart = !tx_full;
        w_data  = 8'h30 + 8'(owner);
        if (wr_uart) state_n = HDR_SEP;
      end
      HDR_SEP: begin
        wr_uart = !tx_full;
        w_data  = 8'h3A;
        if (wr_uart) begin
          state_n = PAYLOAD;
          cnt_n   = '0;
        end
      end
      PAYLOAD: begin
        wr_uart = !tx_full && req_own;
        w_data  = data_own;
        if (wr_uart) begin
          ack   = grant;
          cnt_n = '0;
          if (last_own) begin
            if (ADD_FRAME != 0) begin
              state_n = TRL_CR;
            end else begin
              state_n = IDLE;
              grant_n = '0;
            end
          end
        end else if (!req_own) begin
          // Abort fires on the idle cycle that would bring the count to TIMEOUT.
          if (cnt == CW'(TIMEOUT - 1)) begin
            abort = 1'b1;
            cnt_n = '0;
            if (ADD_FRAME != 0) begin
              state_n = TRL_CR;
            end else begin
              state_n = IDLE;
              grant_n = '0;
            end
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
      end
      TRL_CR: begin
        wr_uart = !tx_full;
        w_data  = 8'h0D;
        if (wr_uart) state_n = TRL_LF;
      end
      TRL_LF: begin
        wr_uart = !tx_full;
        w_data  = 8'h0A;
        if (wr_uart) begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  // State, grant, owner, round-robin pointer and timeout counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= IDXW'(NREQ - 1);
      cnt    <= '0;
    end else begin
      state  <= state_n;
      grant  <= grant_n;
      owner  <= owner_n;
      rr_ptr <= rr_n;
      cnt    <= cnt_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: requester agents drive messages,
// a message-level model pushes the expected UART byte stream into a queue,
// and a monitor pops and compares on every UART write.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // DUT A: 4 requesters, framing on, short timeout
  logic             r_req  [N];
  logic [7:0]       r_data [N];
  logic             r_last [N];
  logic [N-1:0]     req, last, ack, grant;
  logic [8*N-1:0]   data;
  logic             busy, abort, wr_uart, tx_full;
  logic [7:0]       w_data;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req[i]          = r_req[i];
      last[i]         = r_last[i];
      data[8*i +: 8]  = r_data[i];
    end
  end

  uart_tx_arbiter #(.NREQ(N), .ADD_FRAME(1), .TIMEOUT(TO)) dut_a (
    .clk(clk), .reset(rst), .req(req), .data(data), .last(last),
    .ack(ack), .grant(grant), .busy(busy), .abort(abort),
    .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full)
  );

  // DUT B: 2 requesters, no framing
  logic [1:0]  b_req, b_last, b_ack, b_grant;
  logic [15:0] b_data;
  logic        b_busy, b_abort, b_wr, b_txf;
  logic [7:0]  b_wdata;

  uart_tx_arbiter #(.NREQ(2), .ADD_FRAME(0), .TIMEOUT(TO)) dut_b (
    .clk(clk), .reset(rst), .req(b_req), .data(b_data), .last(b_last),
    .ack(b_ack), .grant(b_grant), .busy(b_busy), .abort(b_abort),
    .wr_uart(b_wr), .w_data(b_wdata), .tx_full(b_txf)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  typedef struct packed {
    logic [7:0]   d;
    logic [N-1:0] g;
    logic [N-1:0] a;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] msg[N][$];
  int         last_winner;
  bit         mon_en = 1'b0;
  int         abort_seen = 0;

  function automatic void push_item(input logic [7:0] d, input int id, input bit is_payload);
    exp_t x;
    x.d = d;
    x.g = N'(1) << id;
    x.a = is_payload ? (N'(1) << id) : '0;
    exp_q.push_back(x);
  endfunction

  // All requesters in mask are pending together, so they are served in
  // cyclic order starting just after the previous winner.
  function automatic void push_round(input logic [N-1:0] mask);
    int w = last_winner;
    for (int k = 1; k <= N; k++) begin
      int id = (last_winner + k) % N;
      if (mask[id]) begin
        push_item(8'h30 + 8'(id), id, 1'b0);
        push_item(8'h3A, id, 1'b0);
        foreach (msg[id][b]) push_item(msg[id][b], id, 1'b1);
        push_item(8'h0D, id, 1'b0);
        push_item(8'h0A, id, 1'b0);
        w = id;
      end
    end
    last_winner = w;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (abort) abort_seen++;
      if (mon_en) begin
        if (wr_uart) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got %02h expected no write at %0t", w_data, $time);
          end else begin
            e = exp_q.pop_front();
            check("w_data", w_data, e.d);
            check("grant_on_write", grant, e.g);
            check("ack_on_write", ack, e.a);
          end
        end else begin
          check("ack_no_write", ack, 0);
        end
      end
    end
  end

  // DUT B scoreboard
  logic [7:0] b_exp[$];
  logic [7:0] bb[3];

  always @(negedge clk) begin
    if (!rst) begin
      if (b_wr) begin
        if (b_exp.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_write: got %02h expected no write", b_wdata);
        end else begin
          check("b_w_data", b_wdata, b_exp.pop_front());
          check("b_ack", b_ack, 2'b10);
        end
      end
      if (b_busy) check("b_grant", b_grant, 2'b10);
    end
  end

  // ---------------- tx_full driver ----------------
  bit txf_rand  = 1'b0;
  bit txf_force = 1'b0;

  initial begin
    tx_full = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_full = txf_rand ? ($urandom_range(0, 9) < 3) : txf_force;
    end
  end

  // ---------------- agents and helpers ----------------
  task automatic wait_ack(input int id);
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (ack[id]) begin
        checks++;
        break;
      end
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL ack_wait: requester %0d got no ack, expected one within 2000 cycles", id);
        break;
      end
    end
  endtask

  task automatic agent(input int id, input int gmax);
    int len = msg[id].size();
    for (int b = 0; b < len; b++) begin
      r_req[id]  = 1'b1;
      r_data[id] = msg[id][b];
      r_last[id] = (b == len - 1);
      wait_ack(id);
      @(posedge clk);
      #1;
      r_req[id]  = 1'b0;
      r_last[id] = 1'b0;
      if (b < len - 1 && gmax > 0) begin
        int g = $urandom_range(0, gmax);
        repeat (g) @(posedge clk);
        if (g > 0) #1;
      end
    end
  endtask

  task automatic run_round(input logic [N-1:0] mask, input int gmax);
    push_round(mask);
    fork
      if (mask[0]) agent(0, gmax);
      if (mask[1]) agent(1, gmax);
      if (mask[2]) agent(2, gmax);
      if (mask[3]) agent(3, gmax);
    join
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, exp_q.size(), 0);
    check({name, "_busy"}, busy, 0);
    check({name, "_grant"}, grant, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      r_req[i]  = 1'b0;
      r_last[i] = 1'b0;
      r_data[i] = 8'h00;
      msg[i].delete();
    end
    exp_q.delete();
    last_winner = N - 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bc;
    int n;
    logic [N-1:0] m;

    b_req  = '0;
    b_last = '0;
    b_data = '0;
    b_txf  = 1'b0;
    rst    = 1'b1;
    for (int i = 0; i < N; i++) begin
      r_req[i]  = 1'b0;
      r_last[i] = 1'b0;
      r_data[i] = 8'h00;
    end
    #2;
    check("rst_wr_uart", wr_uart, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_ack", ack, 0);
    check("rst_abort", abort, 0);
    check("rst_w_data", w_data, 0);
    check("rst_b_grant", b_grant, 0);
    check("rst_b_wr", b_wr, 0);
    do_reset();
    mon_en = 1'b1;

    // single framed message: 30 3A 41 42 0D 0A on consecutive cycles
    msg[0] = '{8'h41, 8'h42};
    push_round(4'b0001);
    bc = 0;
    fork
      agent(0, 0);
      for (int c = 0; c < 30; c++) begin
        @(negedge clk);
        if (busy) bc++;
      end
    join
    check("single_busy_cycles", bc, 6);
    wait_empty("single");

    // unframed, 2 requesters: requester 1 sends 3 bytes
    @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      bb[k] = 8'($urandom);
      b_exp.push_back(bb[k]);
    end
    for (int k = 0; k < 3; k++) begin
      b_req[1]      = 1'b1;
      b_data[15:8]  = bb[k];
      b_last[1]     = (k == 2);
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!b_ack[1] && n < 200);
      check("b_ack_seen", b_ack[1], 1);
      @(posedge clk);
      #1;
    end
    b_req  = '0;
    b_last = '0;
    repeat (3) @(negedge clk);
    check("b_drain", b_exp.size(), 0);
    check("b_grant_idle", b_grant, 0);
    check("b_abort", b_abort, 0);

    // round robin from reset, then a {1,3} round
    do_reset();
    for (int i = 0; i < N; i++) msg[i] = '{8'h60 + 8'(i)};
    run_round(4'b1111, 0);
    wait_empty("rr_all");
    msg[1] = '{8'h71};
    msg[3] = '{8'h73};
    run_round(4'b1010, 0);
    wait_empty("rr_13");

    // back-pressure on payload byte 55, longer than the timeout
    msg[0] = '{8'h55};
    push_round(4'b0001);
    fork
      agent(0, 0);
      begin
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!(wr_uart && w_data == 8'h3A) && n < 200);
        check("bp_sep_seen", w_data, 8'h3A);
        @(posedge clk);
        txf_force = 1'b1;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          check("bp_wr_uart", wr_uart, 0);
          check("bp_ack", ack, 0);
          check("bp_w_data", w_data, 8'h55);
          check("bp_abort", abort, 0);
        end
        @(posedge clk);
        txf_force = 1'b0;
        @(negedge clk);
        check("bp_release_wr", wr_uart, 1);
        check("bp_release_ack", ack, 4'b0001);
      end
    join
    wait_empty("bp");

    // timeout: owner drops req after its first byte
    n = abort_seen;
    push_item(8'h30, 0, 1'b0);
    push_item(8'h3A, 0, 1'b0);
    push_item(8'h77, 0, 1'b1);
    push_item(8'h0D, 0, 1'b0);
    push_item(8'h0A, 0, 1'b0);
    last_winner = 0;
    r_req[0]  = 1'b1;
    r_data[0] = 8'h77;
    r_last[0] = 1'b0;
    wait_ack(0);
    @(posedge clk);
    #1;
    r_req[0] = 1'b0;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      check("to_abort_timing", abort, (k == TO) ? 1 : 0);
    end
    @(negedge clk);
    check("to_abort_pulse_end", abort, 0);
    wait_empty("timeout");
    check("to_abort_count", abort_seen - n, 1);
    msg[0] = '{8'h5A};
    run_round(4'b0001, 0);
    wait_empty("to_restart");

    // randomized rounds with random tx_full and sub-timeout gaps
    n = abort_seen;
    txf_rand = 1'b1;
    for (int r = 0; r < 20; r++) begin
      m = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        msg[i].delete();
        for (int b = 0, len = $urandom_range(1, 5); b < len; b++)
          msg[i].push_back(8'($urandom));
      end
      run_round(m, 6);
      wait_empty("rand");
    end
    txf_rand = 1'b0;
    check("rand_no_abort", abort_seen - n, 0);

    // async reset in the middle of a payload
    mon_en = 1'b0;
    @(posedge clk);
    #1;
    r_req[0]  = 1'b1;
    r_data[0] = 8'h11;
    r_last[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[0] && n < 200);
    check("mid_payload_reached", ack, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    check("arst_wr_uart", wr_uart, 0);
    check("arst_ack", ack, 0);
    check("arst_grant", grant, 0);
    check("arst_busy", busy, 0);
    exp_q.delete();
    last_winner = N - 1;
    msg[0] = '{8'h21};
    msg[1] = '{8'h22};
    push_round(4'b0011);
    mon_en = 1'b1;
    fork
      agent(0, 0);
      agent(1, 0);
      begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    wait_empty("arst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion before 500000");
    $fatal(1, "watchdog");
  end

endmodule
